// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, default width, bubble word.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_DROP = 2'd2
   } fetch_state_e;

   localparam int unsigned XLEN_DEFAULT = 32;

   // Presented on o_if_inst whenever the buffer head is empty, so ID sees a bubble.
   localparam logic [31:0] NOP_INST = 32'h0;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: PC register, instruction-memory port and IF/ID boundary.
interface fetch_unit_if
   import fetch_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
);
   logic [XLEN-1:0] i_pc;
   logic            o_pc_write;
   logic            o_imem_req;
   logic [XLEN-1:0] o_imem_addr;
   logic            i_imem_ready;
   logic            i_imem_rvalid;
   logic [XLEN-1:0] i_imem_rdata;
   logic            i_flush;
   logic            i_stall;
   logic            o_if_valid;
   logic [XLEN-1:0] o_if_pc;
   logic [XLEN-1:0] o_if_inst;

   // Fetch unit side.
   modport master (
      input  i_pc, i_imem_ready, i_imem_rvalid, i_imem_rdata, i_flush, i_stall,
      output o_pc_write, o_imem_req, o_imem_addr, o_if_valid, o_if_pc, o_if_inst
   );

   // PC register, memory and decode side.
   modport slave (
      output i_pc, i_imem_ready, i_imem_rvalid, i_imem_rdata, i_flush, i_stall,
      input  o_pc_write, o_imem_req, o_imem_addr, o_if_valid, o_if_pc, o_if_inst
   );
endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, inst} words with synchronous clear; count spans 0..DEPTH.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 2 * XLEN_DEFAULT,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = PW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enq,
   input  logic             deq,
   input  logic             clear,
   input  logic [WIDTH-1:0] wdata,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    count_q;

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (clear) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (enq) wptr_q <= wptr_q + PW'(1);
         if (deq) rptr_q <= rptr_q + PW'(1);
         count_q <= count_q + CW'(enq) - CW'(deq);
      end
   end

   always_ff @(posedge clk) begin
      if (enq && !clear) mem_q[wptr_q] <= wdata;
   end

   assign count = count_q;
   assign rdata = mem_q[rptr_q];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, responses tagged with their PC and buffered.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned XLEN  = XLEN_DEFAULT
) (
   input logic         clk,
   input logic         reset,
   fetch_unit_if.master bus
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_e      state_q, state_d;
   logic [XLEN-1:0]   tag_q;
   logic [CW-1:0]     count, occ_next;
   logic [2*XLEN-1:0] head;
   logic              head_valid, enq, deq, req, accept;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2 * XLEN)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .enq   (enq),
      .deq   (deq),
      .clear (bus.i_flush),
      .wdata ({tag_q, bus.i_imem_rdata}),
      .count (count),
      .rdata (head)
   );

   assign head_valid = (count != '0);
   assign enq        = (state_q == FETCH_WAIT) && bus.i_imem_rvalid && !bus.i_flush;
   assign deq        = head_valid && !bus.i_stall && !bus.i_flush;
   assign occ_next   = count + CW'(enq) - CW'(deq);

   // Gating with reset keeps the memory port quiet while reset is held.
   assign req    = reset && !bus.i_flush && (occ_next < CW'(DEPTH)) &&
                   ((state_q == FETCH_IDLE) || (state_q == FETCH_WAIT && bus.i_imem_rvalid));
   assign accept = req && bus.i_imem_ready;

   assign bus.o_imem_req  = req;
   assign bus.o_imem_addr = bus.i_pc;
   assign bus.o_pc_write  = accept;
   assign bus.o_if_valid  = head_valid;
   assign bus.o_if_pc     = head_valid ? head[2*XLEN-1:XLEN] : '0;
   assign bus.o_if_inst   = head_valid ? head[XLEN-1:0] : XLEN'(NOP_INST);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FETCH_IDLE: if (accept) state_d = FETCH_WAIT;
         FETCH_WAIT: begin
            if (bus.i_flush)         state_d = bus.i_imem_rvalid ? FETCH_IDLE : FETCH_DROP;
            else if (bus.i_imem_rvalid) state_d = accept ? FETCH_WAIT : FETCH_IDLE;
         end
         FETCH_DROP: if (bus.i_imem_rvalid) state_d = FETCH_IDLE;
         default:    state_d = FETCH_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH_IDLE;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) tag_q <= bus.i_pc;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model returns pc+0x100, scoreboard of expected {pc, inst}.
module tb_fetch_unit;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   typedef struct {
      bit          rst;
      bit          stall;
      bit          ready;
      bit          exp_pcw;
      bit          exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_inst;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fetch_unit_if #(.XLEN(32)) bus ();

   fetch_unit #(
      .DEPTH (2),
      .XLEN  (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   vec_t vq[$];

   logic [31:0] pc = 32'h0;
   logic [31:0] mem_addr = 32'h0;
   bit          mem_busy = 0;
   int          mem_cnt = 0;
   int          lat = 1;

   logic        s_req, s_pcw, s_valid;
   logic [31:0] s_addr, s_pc, s_inst;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input bit rst, input bit stall, input bit ready, input bit pcw,
                      input bit valid, input logic [31:0] epc, input logic [31:0] einst);
      vec_t v;
      v.rst = rst; v.stall = stall; v.ready = ready; v.exp_pcw = pcw;
      v.exp_valid = valid; v.exp_pc = epc; v.exp_inst = einst;
      vq.push_back(v);
   endtask

   // One clock cycle: drive at negedge, sample 1 time unit later, update models.
   task automatic step(input bit rst, input bit stall, input bit ready, input bit flush,
                       input logic [31:0] target, input bit stray);
      bit model_rv;
      exp_t e;
      @(negedge clk);
      model_rv          = !rst && mem_busy && mem_cnt == 0;
      reset             = !rst;
      bus.i_pc          = pc;
      bus.i_stall       = stall;
      bus.i_imem_ready  = ready;
      bus.i_flush       = flush;
      bus.i_imem_rvalid = model_rv || stray;
      bus.i_imem_rdata  = stray ? 32'hDEAD : mem_addr + 32'h100;
      #1;
      s_req = bus.o_imem_req; s_pcw = bus.o_pc_write; s_addr = bus.o_imem_addr;
      s_valid = bus.o_if_valid; s_pc = bus.o_if_pc; s_inst = bus.o_if_inst;
      if (rst) begin
         sb.delete();
         pc = 32'h0;
         mem_busy = 0;
         return;
      end
      if (s_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL head_unexpected: got pc %0h, expected no valid head", s_pc);
         end else begin
            check("head_pc", s_pc, sb[0].pc);
            check("head_inst", s_inst, sb[0].inst);
            if (!stall && !flush) void'(sb.pop_front());
         end
      end
      if (flush) begin
         sb.delete();
         pc = target;
      end
      if (model_rv) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (s_pcw) begin
         check("one_outstanding", mem_busy, 0);
         check("req_addr", s_addr, pc);
         e.pc = s_addr;
         e.inst = s_addr + 32'h100;
         sb.push_back(e);
         pc = pc + 32'h4;
         mem_busy = 1;
         mem_cnt = lat - 1;
         mem_addr = s_addr;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish within budget");
      $fatal(1, "timeout");
   end

   initial begin
      bit found;
      bus.i_pc = '0; bus.i_imem_ready = 0; bus.i_imem_rvalid = 0; bus.i_imem_rdata = '0;
      bus.i_flush = 0; bus.i_stall = 0;

      // reset, streaming, stall hold, ready backpressure
      add(1, 0, 1, 0, 0, 32'h0, 32'h0);
      add(0, 0, 1, 1, 0, 32'h0, 32'h0);
      add(0, 0, 1, 1, 0, 32'h0, 32'h0);
      add(0, 0, 1, 1, 1, 32'h0, 32'h100);
      add(0, 0, 1, 1, 1, 32'h4, 32'h104);
      add(0, 0, 1, 1, 1, 32'h8, 32'h108);
      add(1, 0, 1, 0, 0, 32'h0, 32'h0);
      add(0, 0, 1, 1, 0, 32'h0, 32'h0);
      add(0, 0, 1, 1, 0, 32'h0, 32'h0);
      add(0, 1, 1, 0, 1, 32'h0, 32'h100);
      add(0, 1, 1, 0, 1, 32'h0, 32'h100);
      add(0, 1, 1, 0, 1, 32'h0, 32'h100);
      add(0, 0, 1, 1, 1, 32'h0, 32'h100);
      add(0, 0, 1, 1, 1, 32'h4, 32'h104);
      add(0, 0, 1, 1, 1, 32'h8, 32'h108);
      add(1, 0, 1, 0, 0, 32'h0, 32'h0);
      add(0, 0, 0, 0, 0, 32'h0, 32'h0);
      add(0, 0, 0, 0, 0, 32'h0, 32'h0);
      add(0, 0, 0, 0, 0, 32'h0, 32'h0);
      add(0, 0, 1, 1, 0, 32'h0, 32'h0);
      add(0, 0, 1, 1, 0, 32'h0, 32'h0);
      add(0, 0, 1, 1, 1, 32'h0, 32'h100);

      foreach (vq[i]) begin
         step(vq[i].rst, vq[i].stall, vq[i].ready, 0, 32'h0, 0);
         check($sformatf("vec%0d_pc_write", i), s_pcw, vq[i].exp_pcw);
         check($sformatf("vec%0d_valid", i), s_valid, vq[i].exp_valid);
         check($sformatf("vec%0d_if_pc", i), s_pc, vq[i].exp_pc);
         check($sformatf("vec%0d_if_inst", i), s_inst, vq[i].exp_inst);
      end

      // flush while 0x8 is outstanding on a 3-cycle memory
      lat = 3;
      step(1, 0, 1, 0, 32'h0, 0);
      found = 0;
      for (int i = 0; i < 40; i++) begin
         step(0, 0, 1, 0, 32'h0, 0);
         if (s_pcw && s_addr == 32'h8) begin found = 1; break; end
      end
      check("drop_accept_0x8", found, 1);
      step(0, 0, 1, 1, 32'h40, 0);
      check("drop_flush_no_req", s_req, 0);
      step(0, 0, 1, 0, 32'h0, 0);
      check("drop_valid_cleared", s_valid, 0);
      found = 0;
      for (int i = 0; i < 40; i++) begin
         step(0, 0, 1, 0, 32'h0, 0);
         if (s_valid) begin found = 1; break; end
      end
      check("drop_first_out_seen", found, 1);
      check("drop_first_pc", s_pc, 32'h40);
      check("drop_first_inst", s_inst, 32'h140);

      // flush in the same cycle as the response for 0x4
      lat = 1;
      step(1, 0, 1, 0, 32'h0, 0);
      found = 0;
      for (int i = 0; i < 10; i++) begin
         if (mem_busy && mem_cnt == 0 && mem_addr == 32'h4) begin
            step(0, 0, 1, 1, 32'h80, 0);
            found = 1;
            break;
         end
         step(0, 0, 1, 0, 32'h0, 0);
      end
      check("rvflush_reached", found, 1);
      check("rvflush_no_req", s_req, 0);
      step(0, 0, 1, 0, 32'h0, 0);
      check("rvflush_empty", s_valid, 0);
      found = 0;
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, 0, 32'h0, 0);
         if (s_valid) begin found = 1; break; end
      end
      check("rvflush_out_seen", found, 1);
      check("rvflush_first_pc", s_pc, 32'h80);
      check("rvflush_first_inst", s_inst, 32'h180);

      // reset while waiting, then a stray response
      lat = 3;
      step(1, 0, 1, 0, 32'h0, 0);
      step(0, 0, 1, 0, 32'h0, 0);
      step(0, 0, 1, 0, 32'h0, 0);
      step(1, 0, 1, 0, 32'h0, 0);
      check("midreset_valid", s_valid, 0);
      step(0, 0, 1, 0, 32'h0, 1);
      check("stray_restart_pcw", s_pcw, 1);
      check("stray_restart_addr", s_addr, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 0, 32'h0, 0);
         check($sformatf("stray_no_valid%0d", i), s_valid, 0);
      end
      step(0, 0, 1, 0, 32'h0, 0);
      check("stray_first_valid", s_valid, 1);
      check("stray_first_pc", s_pc, 32'h0);
      check("stray_first_inst", s_inst, 32'h100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC and issues one instruction-memory request per cycle. It tells the PC register when to advance.
- Returns {pc, inst} pairs through a small buffer into the IF/ID boundary, with stall (hold) and flush (branch redirect) support.
- At most one memory request is outstanding at any time.

Parameters:
- DEPTH, 2, number of entries in the fetched-instruction buffer (power of 2, ≥2).
- XLEN, 32, PC and instruction width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- i_pc  input  XLEN  current PC from the PC register; used as the fetch address.
- o_pc_write  output  1  drives the PC register's write enable. It is 1 exactly in cycles where a memory request is accepted.
- o_imem_req  output  1  memory request valid.
- o_imem_addr  output  XLEN  request address; equals i_pc.
- i_imem_ready  input  1  memory accepts the request this cycle when o_imem_req is also 1.
- i_imem_rvalid  input  1  read data valid; arrives at least 1 cycle after acceptance.
- i_imem_rdata  input  XLEN  instruction word.
- i_flush  input  1  redirect; discard all buffered and in-flight instructions.
- i_stall  input  1  ID stage cannot accept; hold the buffer head.
- o_if_valid  output  1  buffer head valid.
- o_if_pc  output  XLEN  PC of the buffer head.
- o_if_inst  output  XLEN  instruction of the buffer head.

Behaviour:
- Reset (reset==0, asynchronous): state IDLE, buffer empty, so o_if_valid=0, o_if_pc=0, o_if_inst=0.
  - o_imem_req=0 and o_pc_write=0 while reset is asserted.
- States:
  - IDLE: nothing outstanding.
  - WAIT: one request outstanding.
  - DROP: one request outstanding whose data must be discarded.
- Enqueue and dequeue:
  - enq = (state==WAIT) && i_imem_rvalid && !i_flush. It writes {address of that request, i_imem_rdata}.
  - deq = o_if_valid && !i_stall && !i_flush.
  - occ_next = count + enq − deq.
- Issue (combinational):
  - o_imem_req = !i_flush && (state==IDLE || (state==WAIT && i_imem_rvalid)) && occ_next < DEPTH.
  - o_imem_addr = i_pc.
  - o_pc_write = o_imem_req && i_imem_ready.
  - Accepted request address is registered as the tag for the response.
- Transitions:
  - IDLE → WAIT on acceptance.
  - WAIT, rvalid, no new acceptance → IDLE.
  - WAIT, rvalid, new acceptance → WAIT (back-to-back; throughput 1 instr/cycle with 1-cycle memory).
  - WAIT, i_flush, no rvalid → DROP.
  - WAIT, i_flush, rvalid same cycle → IDLE, data dropped.
  - DROP, rvalid → IDLE, data dropped, no issue in that cycle.
  - DROP ignores i_flush.
- Flush has top priority: buffer cleared (o_if_valid=0 next cycle), no issue, no enqueue. The top level muxes the redirect target into the PC register using i_flush as an extra write enable.
- Stall blocks dequeue only. Fetch continues until the buffer plus the outstanding request fill DEPTH.
- Latency:
  - Request accepted at cycle t, rvalid at t+1 → o_if_valid=1 at t+2 (registered buffer, no bypass).
- Buffer is a circular FIFO with wrapping read/write pointers; count ranges 0..DEPTH. Overflow is impossible by the issue rule.
- i_imem_rvalid in IDLE is ignored; this covers stray responses after reset.
- Reset asserted mid-WAIT: the outstanding request is forgotten and any later response is ignored.
- Outputs hold their value while i_stall=1.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding FETCH_IDLE=2'd0, FETCH_WAIT=2'd1, FETCH_DROP=2'd2;
  - XLEN default;
  - NOP instruction constant 32'h0, used by the top level to bubble ID when o_if_valid=0.
- One sub-module, fetch_fifo: parameterised DEPTH×(2·XLEN) buffer with enq, deq, clear, count, head data. Same clk/reset convention.

Test Plan:
- Reset, then release with i_pc=0x0, ready=1, rvalid one cycle after each acceptance, memory[pc]=pc+0x100 → o_if_valid from cycle 2, sequence (0x0,0x100),(0x4,0x104),(0x8,0x108) one per cycle; o_pc_write=1 every cycle.
- Hold i_stall=1 from the first valid output → at most DEPTH=2 buffered plus 0 outstanding. o_imem_req drops to 0 and head stays (0x0,0x100). Release stall → next head (0x4,0x104), no loss or duplication.
- i_imem_ready=0 for 3 cycles → o_pc_write=0, PC not advanced, no valid output appears; ready=1 → fetch resumes at the same address.
- Memory latency 3 cycles, i_flush pulsed 1 cycle after acceptance of 0x8 (state WAIT→DROP) with redirect to 0x40 → response for 0x8 discarded, o_if_valid=0. The first instruction out afterwards is (0x40,0x140).
- i_flush coincident with rvalid for 0x4 → 0x4 dropped, buffer empty next cycle, no request issued in the flush cycle.
- reset driven to 0 mid-WAIT, released, then a stray rvalid with 0xDEAD → ignored, o_if_valid stays 0, fetch restarts from PC 0x0.
